// File: rtl/y_edge_pkg.sv
// ============================================================================
//  y_edge_pkg : shared types and default constants for y_edge_tracker
//  Rev 1.0
// ============================================================================
`default_nettype none

package y_edge_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF           = 16;
    localparam int DEB_W               = 8;

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_CONF_H = 2'd1,
        ST_HIGH   = 2'd2,
        ST_CONF_L = 2'd3
    } edge_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
//  sync_2ff : two-flop synchronizer for a single asynchronous bit
//  Rev 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/y_edge_tracker.sv
// ============================================================================
//  y_edge_tracker : debounces an asynchronous Y level, emits edge pulses and
//  tracks rise count and the length of the last completed high period.
//  Rev 1.0
// ============================================================================
`default_nettype none

module y_edge_tracker
    import y_edge_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             y_in,
    input  logic             enable,
    input  logic             clear,
    output logic             y_stable,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] rise_count,
    output logic [CNT_W-1:0] high_len,
    output logic             high_len_valid,
    output logic             overflow
);

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic y_s;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (y_in),
        .q_o   (y_s)
    );

    edge_state_e      state_q, state_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             rise_ev, fall_ev;

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        rise_ev   = 1'b0;
        fall_ev   = 1'b0;
        case (state_q)
            ST_LOW: begin
                if (y_s) begin
                    state_d   = ST_CONF_H;
                    deb_cnt_d = DEB_W'(1);
                end
            end
            ST_CONF_H: begin
                if (!y_s) begin
                    state_d   = ST_LOW;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = ST_HIGH;
                    deb_cnt_d = '0;
                    rise_ev   = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            ST_HIGH: begin
                if (!y_s) begin
                    state_d   = ST_CONF_L;
                    deb_cnt_d = DEB_W'(1);
                end
            end
            ST_CONF_L: begin
                if (y_s) begin
                    state_d   = ST_HIGH;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = ST_LOW;
                    deb_cnt_d = '0;
                    fall_ev   = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: begin
                state_d   = ST_LOW;
                deb_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_LOW;
            deb_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    logic             y_stable_q, rise_pulse_q, fall_pulse_q;
    logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] high_len_q, high_len_d;
    logic             hlv_q, hlv_d;
    logic             ovf_q, ovf_d;

    // Statistics update on the same edge the FSM accepts an edge, so the
    // counters line up with the registered pulses.
    always_comb begin
        rise_cnt_d = rise_cnt_q;
        hi_cnt_d   = hi_cnt_q;
        high_len_d = high_len_q;
        hlv_d      = 1'b0;
        ovf_d      = ovf_q;
        if (clear) begin
            rise_cnt_d = '0;
            hi_cnt_d   = '0;
            high_len_d = '0;
            ovf_d      = 1'b0;
        end else if (enable) begin
            if (rise_ev) begin
                hi_cnt_d = CNT_W'(1);
                if (rise_cnt_q == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    rise_cnt_d = rise_cnt_q + CNT_W'(1);
                end
            end else if (y_stable_q) begin
                if (hi_cnt_q == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    hi_cnt_d = hi_cnt_q + CNT_W'(1);
                end
            end
            if (fall_ev) begin
                high_len_d = hi_cnt_q;
                hlv_d      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_stable_q   <= 1'b0;
            rise_pulse_q <= 1'b0;
            fall_pulse_q <= 1'b0;
            rise_cnt_q   <= '0;
            hi_cnt_q     <= '0;
            high_len_q   <= '0;
            hlv_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            y_stable_q   <= (state_d == ST_HIGH) || (state_d == ST_CONF_L);
            rise_pulse_q <= rise_ev;
            fall_pulse_q <= fall_ev;
            rise_cnt_q   <= rise_cnt_d;
            hi_cnt_q     <= hi_cnt_d;
            high_len_q   <= high_len_d;
            hlv_q        <= hlv_d;
            ovf_q        <= ovf_d;
        end
    end

    assign y_stable       = y_stable_q;
    assign rise_pulse     = rise_pulse_q;
    assign fall_pulse     = fall_pulse_q;
    assign rise_count     = rise_cnt_q;
    assign high_len       = high_len_q;
    assign high_len_valid = hlv_q;
    assign overflow       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_y_edge_tracker.sv
// ============================================================================
//  tb_y_edge_tracker : vector-table bench for y_edge_tracker (default and
//  CNT_W=4 instances driven from the same inputs).
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_y_edge_tracker;

    logic clk = 1'b0;
    logic rst_n, y_in, enable, clear;

    logic        st, rp, fp, hlv, ovf;
    logic [15:0] rc, hl;
    logic        st4, rp4, fp4, hlv4, ovf4;
    logic [3:0]  rc4, hl4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    y_edge_tracker dut (
        .clk(clk), .rst_n(rst_n), .y_in(y_in), .enable(enable), .clear(clear),
        .y_stable(st), .rise_pulse(rp), .fall_pulse(fp), .rise_count(rc),
        .high_len(hl), .high_len_valid(hlv), .overflow(ovf)
    );

    y_edge_tracker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .y_in(y_in), .enable(enable), .clear(clear),
        .y_stable(st4), .rise_pulse(rp4), .fall_pulse(fp4), .rise_count(rc4),
        .high_len(hl4), .high_len_valid(hlv4), .overflow(ovf4)
    );

    typedef struct {
        logic        y, en, clr;
        logic        st, rp, fp;
        logic [15:0] rc, hl;
        logic        hlv, ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic y, input logic en, input logic clr,
                       input logic est, input logic erp, input logic efp,
                       input logic [15:0] erc, input logic [15:0] ehl,
                       input logic ehlv, input logic eovf);
        vec_t v;
        v.y = y; v.en = en; v.clr = clr;
        v.st = est; v.rp = erp; v.fp = efp;
        v.rc = erc; v.hl = ehl; v.hlv = ehlv; v.ovf = eovf;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int hi_cycles, input int lo_cycles);
        y_in = 1'b1; cyc(hi_cycles);
        y_in = 1'b0; cyc(lo_cycles);
    endtask

    task automatic chk_all_zero(input string nm, input int idx);
        chk(nm, idx, {15'd0, st, rp, fp, hlv, ovf, rc}, 32'd0);
        chk({nm, "_hl"}, idx, {16'd0, hl}, 32'd0);
        chk({nm, "_w4"}, idx, {20'd0, st4, rp4, fp4, hlv4, ovf4, rc4, hl4}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; y_in = 1'b0; enable = 1'b1; clear = 1'b0;
        cyc(3);
        chk_all_zero("reset", 0);

        // Glitch of 3 cycles is rejected
        add(3,  1, 1, 0, 0, 0, 0, 16'd0, 16'd0,  0, 0);
        add(4,  0, 1, 0, 0, 0, 0, 16'd0, 16'd0,  0, 0);
        // Rise accepted at edge 5, 20-cycle high period
        add(5,  1, 1, 0, 0, 0, 0, 16'd0, 16'd0,  0, 0);
        add(1,  1, 1, 0, 1, 1, 0, 16'd1, 16'd0,  0, 0);
        add(14, 1, 1, 0, 1, 0, 0, 16'd1, 16'd0,  0, 0);
        add(5,  0, 1, 0, 1, 0, 0, 16'd1, 16'd0,  0, 0);
        add(1,  0, 1, 0, 0, 0, 1, 16'd1, 16'd20, 1, 0);
        add(2,  0, 1, 0, 0, 0, 0, 16'd1, 16'd20, 0, 0);
        // Three pulses with enable low: pulses still fire, stats frozen
        for (int p = 0; p < 3; p++) begin
            add(5, 1, 0, 0, 0, 0, 0, 16'd1, 16'd20, 0, 0);
            add(1, 1, 0, 0, 1, 1, 0, 16'd1, 16'd20, 0, 0);
            add(5, 0, 0, 0, 1, 0, 0, 16'd1, 16'd20, 0, 0);
            add(1, 0, 0, 0, 0, 0, 1, 16'd1, 16'd20, 0, 0);
        end
        // Enabled 6-cycle pulse
        add(5,  1, 1, 0, 0, 0, 0, 16'd1, 16'd20, 0, 0);
        add(1,  1, 1, 0, 1, 1, 0, 16'd2, 16'd20, 0, 0);
        add(5,  0, 1, 0, 1, 0, 0, 16'd2, 16'd20, 0, 0);
        add(1,  0, 1, 0, 0, 0, 1, 16'd2, 16'd6,  1, 0);
        // Clear coinciding with rise, then with fall
        add(5,  1, 1, 0, 0, 0, 0, 16'd2, 16'd6,  0, 0);
        add(1,  1, 1, 1, 1, 1, 0, 16'd0, 16'd0,  0, 0);
        add(5,  0, 1, 0, 1, 0, 0, 16'd0, 16'd0,  0, 0);
        add(1,  0, 1, 1, 0, 0, 1, 16'd0, 16'd0,  0, 0);
        add(1,  0, 1, 0, 0, 0, 0, 16'd0, 16'd0,  0, 0);

        rst_n = 1'b1;
        foreach (vecs[i]) begin
            y_in = vecs[i].y; enable = vecs[i].en; clear = vecs[i].clr;
            cyc(1);
            chk("y_stable",   i, {31'd0, st},  {31'd0, vecs[i].st});
            chk("rise_pulse", i, {31'd0, rp},  {31'd0, vecs[i].rp});
            chk("fall_pulse", i, {31'd0, fp},  {31'd0, vecs[i].fp});
            chk("rise_count", i, {16'd0, rc},  {16'd0, vecs[i].rc});
            chk("high_len",   i, {16'd0, hl},  {16'd0, vecs[i].hl});
            chk("hl_valid",   i, {31'd0, hlv}, {31'd0, vecs[i].hlv});
            chk("overflow",   i, {31'd0, ovf}, {31'd0, vecs[i].ovf});
        end
        enable = 1'b1; clear = 1'b0; y_in = 1'b0;

        // Narrow counter saturation: 15 rises fit, the 16th overflows
        clear = 1'b1; cyc(1); clear = 1'b0;
        for (int p = 0; p < 15; p++) pulse(6, 6);
        chk("sat_rc15",   15, {28'd0, rc4}, 32'd15);
        chk("sat_noovf",  15, {31'd0, ovf4}, 32'd0);
        pulse(6, 6);
        chk("sat_rc_w4",  16, {28'd0, rc4}, 32'd15);
        chk("sat_ovf_w4", 16, {31'd0, ovf4}, 32'd1);
        chk("sat_rc_w16", 16, {16'd0, rc}, 32'd16);
        chk("sat_ovf16",  16, {31'd0, ovf}, 32'd0);
        chk("sat_hl_w4",  16, {28'd0, hl4}, 32'd6);
        clear = 1'b1; cyc(1); clear = 1'b0;
        chk_all_zero("clear_all", 17);

        // Reset while confirming a rise, then rise timing after release
        y_in = 1'b1; cyc(4);
        chk("conf_h_st", 0, {31'd0, st}, 32'd0);
        rst_n = 1'b0; cyc(1);
        chk_all_zero("rst_conf_h", 0);
        rst_n = 1'b1; cyc(5);
        chk("post_rst_e4", 4, {31'd0, st}, 32'd0);
        cyc(1);
        chk("post_rst_e5", 5, {30'd0, st, rp}, 32'd3);
        chk("post_rst_rc", 5, {16'd0, rc}, 32'd1);
        cyc(5);
        chk("high_hold", 10, {30'd0, st, rp}, 32'd2);
        rst_n = 1'b0; cyc(1);
        chk_all_zero("rst_high", 0);
        y_in = 1'b0; rst_n = 1'b1; cyc(3);
        chk_all_zero("after_rst", 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
